// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone DRAM arbiter: FSM states, default bus
// widths matching the interconnect, and an elaboration-time clog2 helper.
package wb_arb_pkg;

    localparam int DEF_AW = 36;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_dram_arbiter_rr_pick.sv
// Rotating-priority selector: scans req starting at last+1 (wrapping modulo
// NM) and returns the first requester as both one-hot and encoded index.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = 4,
    parameter int IW = clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos [NM];

    // Candidate index for each scan step, in priority order.
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            pos[i] = IW'((int'(last) + i + 1) % NM);
        end
    end

    // First requester in scan order wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (!any && req[pos[i]]) begin
                any         = 1'b1;
                gnt[pos[i]] = 1'b1;
                idx         = pos[i];
            end
        end
    end

endmodule

// File: rtl/wb_dram_arbiter.sv
// Round-robin arbiter sharing one Wishbone DRAM slave among NM masters.
// A grant is held for the owner's whole cyc window; a watchdog aborts an
// owner whose strobe goes unacknowledged for TIMEOUT cycles.
module wb_dram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NM      = 4,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NM*AW-1:0]       m_adr_i,
    input  logic [NM*DW-1:0]       m_dat_i,
    input  logic [NM*(DW/8)-1:0]   m_sel_i,
    input  logic [NM-1:0]          m_we_i,
    input  logic [NM-1:0]          m_cyc_i,
    input  logic [NM-1:0]          m_stb_i,
    output logic [DW-1:0]          m_dat_o,
    output logic [NM-1:0]          m_ack_o,
    output logic [NM-1:0]          m_err_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    output logic [(DW/8)-1:0]      s_sel_o,
    output logic                   s_we_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    input  logic [DW-1:0]          s_dat_i,
    input  logic                   s_ack_i,
    output logic [NM-1:0]          grant_o,
    output logic                   abort_o
);

    localparam int SW = DW / 8;
    localparam int IW = clog2(NM);
    // Watchdog counter must hold TIMEOUT; keep one bit when disabled.
    localparam int WW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

    arb_state_t    state_q, state_d;
    logic [NM-1:0] grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [WW-1:0] wd_q, wd_d;

    logic [NM-1:0] pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    logic [AW-1:0] adr_arr [NM];
    logic [DW-1:0] dat_arr [NM];
    logic [SW-1:0] sel_arr [NM];

    logic own_cyc, own_stb, own_we;
    logic in_grant, stalled, expire;

    rr_pick #(
        .NM (NM),
        .IW (IW)
    ) u_pick (
        .req  (m_cyc_i),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Unpack the flattened master buses so the owner can be selected by index.
    always_comb begin
        for (int k = 0; k < NM; k++) begin
            adr_arr[k] = m_adr_i[k*AW +: AW];
            dat_arr[k] = m_dat_i[k*DW +: DW];
            sel_arr[k] = m_sel_i[k*SW +: SW];
        end
    end

    // last_q doubles as the owner index while a grant is active.
    assign own_cyc  = m_cyc_i[last_q];
    assign own_stb  = m_stb_i[last_q];
    assign own_we   = m_we_i[last_q];
    assign in_grant = (state_q == ST_GRANT);

    // Address/data lines follow the owner; controls are gated by the grant so
    // that an asynchronous reset drops them without waiting for a clock.
    assign s_adr_o = adr_arr[last_q];
    assign s_dat_o = dat_arr[last_q];
    assign s_sel_o = sel_arr[last_q];
    assign s_cyc_o = in_grant & own_cyc;
    assign s_stb_o = in_grant & own_cyc & own_stb;
    assign s_we_o  = in_grant & own_we;

    // Acks reach the owner only while granted, so late acks are swallowed.
    assign m_dat_o = s_dat_i;
    assign m_ack_o = in_grant ? (grant_o & {NM{s_ack_i}}) : '0;
    assign m_err_o = (state_q == ST_ABORT) ? grant_o : '0;
    assign abort_o = (state_q == ST_ABORT);

    // An ack in the expiry cycle is not a stall, so the ack wins.
    assign stalled = s_stb_o & ~s_ack_i;
    assign expire  = (TIMEOUT != 0) && stalled && (wd_q == WW'(TIMEOUT - 1));

    // Next-state, grant and watchdog update.
    always_comb begin
        state_d = state_q;
        grant_d = grant_o;
        last_d  = last_q;
        wd_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    grant_d = pick_gnt;
                    last_d  = pick_idx;
                end
            end
            ST_GRANT: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (expire) begin
                    state_d = ST_ABORT;
                end else if (stalled && (TIMEOUT != 0)) begin
                    wd_d = wd_q + WW'(1);
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant, round-robin pointer and watchdog registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_o <= '0;
            last_q  <= IW'(NM - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_o <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_dram_arbiter.sv
// Scoreboard bench for wb_dram_arbiter: stimulus pushes expected grants, acks
// and errors; a monitor pops and compares whenever the DUT presents them.
module tb_wb_dram_arbiter;

    localparam int NM  = 4;
    localparam int AW  = 36;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NM*AW-1:0] m_adr = '0;
    logic [NM*DW-1:0] m_dat = '0;
    logic [NM*SW-1:0] m_sel = '0;
    logic [NM-1:0]    m_we  = '0;
    logic [NM-1:0]    m_cyc = '0;
    logic [NM-1:0]    m_stb = '0;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SW-1:0]    s_sel_o;
    logic             s_we_o, s_cyc_o, s_stb_o, abort_o;
    logic [DW-1:0]    s_dat_i = '0;
    logic             s_ack_i = 1'b0;

    wb_dram_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .abort_o(abort_o)
    );

    typedef struct {
        int             m;
        logic           we;
        logic [AW-1:0]  adr;
        logic [SW-1:0]  sel;
        logic [DW-1:0]  dat;
    } ack_t;

    ack_t exp_ack[$];
    int   exp_grant[$];
    int   exp_err[$];

    int checks = 0;
    int errors = 0;
    int model_last = NM - 1;
    int grant_cnt [NM];
    int abort_cnt = 0;

    logic [DW-1:0] ref_mem   [logic [AW-1:0]];
    logic [DW-1:0] slave_mem [logic [AW-1:0]];
    bit stall = 1'b0;
    int fixed_delay = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s actual=%s required=expected-event", name, what);
    endtask

    // Round-robin rule: first requester after the last owner, wrapping.
    function automatic int pick(input logic [NM-1:0] reqs, input int last);
        for (int i = 1; i <= NM; i++) begin
            if (reqs[(last + i) % NM]) return (last + i) % NM;
        end
        return -1;
    endfunction

    // DRAM slave model: acks after a number of stalled cycles, one-cycle ack.
    initial begin
        int cnt;
        int rnd;
        cnt = 0;
        rnd = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || s_ack_i) begin
                s_ack_i = 1'b0;
                cnt = 0;
            end else if (s_cyc_o && s_stb_o && !stall) begin
                if (cnt >= ((fixed_delay >= 0) ? fixed_delay : rnd)) begin
                    s_ack_i = 1'b1;
                    if (s_we_o) slave_mem[s_adr_o] = s_dat_o;
                    else s_dat_i = slave_mem.exists(s_adr_o) ? slave_mem[s_adr_o] : '0;
                    cnt = 0;
                    rnd = $urandom_range(0, 3);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compares every ack, err and new grant against the queues.
    initial begin
        logic [NM-1:0] prev;
        ack_t e;
        int g;
        prev = '0;
        forever begin
            @(negedge clk);
            if (m_ack_o != '0) begin
                if (exp_ack.size() == 0) fail("ack_unexpected", "ack");
                else begin
                    e = exp_ack.pop_front();
                    chk("ack_owner", 64'(m_ack_o), 64'(1) << e.m);
                    chk("ack_adr", 64'(s_adr_o), 64'(e.adr));
                    chk("ack_we", 64'(s_we_o), 64'(e.we));
                    chk("ack_sel", 64'(s_sel_o), 64'(e.sel));
                    if (e.we) chk("wr_dat", 64'(s_dat_o), 64'(e.dat));
                    else      chk("rd_dat", 64'(m_dat_o), 64'(e.dat));
                end
            end
            if (m_err_o != '0 || abort_o) begin
                abort_cnt++;
                if (exp_err.size() == 0) fail("err_unexpected", "err");
                else begin
                    g = exp_err.pop_front();
                    chk("err_owner", 64'(m_err_o), 64'(1) << g);
                    chk("abort_pulse", 64'(abort_o), 64'd1);
                    chk("abort_cyc", 64'(s_cyc_o), 64'd0);
                end
            end
            if (grant_o != prev) begin
                chk("dead_cycle", 64'((prev == '0) || (grant_o == '0)), 64'd1);
                if (grant_o != '0) begin
                    if (exp_grant.size() == 0) fail("grant_unexpected", "grant");
                    else begin
                        g = exp_grant.pop_front();
                        chk("grant_order", 64'(grant_o), 64'(1) << g);
                        grant_cnt[g]++;
                    end
                end
            end
            prev = grant_o;
        end
    end

    task automatic wait_grant(input int m);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (grant_o[m]) return;
        end
        fail("grant_wait", "timeout");
    endtask

    // One Wishbone beat; called at posedge+1, returns at posedge+1 after ack.
    task automatic do_beat(input int m, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        ack_t e;
        bit got;
        got = 1'b0;
        e.m = m; e.we = we; e.adr = adr; e.sel = sel;
        e.dat = we ? dat : (ref_mem.exists(adr) ? ref_mem[adr] : '0);
        if (we) ref_mem[adr] = dat;
        exp_ack.push_back(e);
        m_adr[m*AW +: AW] = adr;
        m_dat[m*DW +: DW] = dat;
        m_sel[m*SW +: SW] = sel;
        m_we[m]  = we;
        m_stb[m] = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (m_ack_o[m]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("ack_wait", "timeout");
        @(posedge clk);
        #1;
        m_stb[m] = 1'b0;
    endtask

    task automatic rand_beat(input int m);
        logic [AW-1:0] adr;
        adr = AW'(36'h1000 + 4 * $urandom_range(0, 7));
        do_beat(m, 1'($urandom_range(0, 1)), adr, $urandom, SW'($urandom_range(1, 15)));
    endtask

    // Wait for the grant, run n beats, release cyc.
    task automatic tenure(input int m, input int nbeats);
        wait_grant(m);
        @(posedge clk);
        #1;
        for (int b = 0; b < nbeats; b++) rand_beat(m);
        m_cyc[m] = 1'b0;
    endtask

    task automatic contest(input logic [NM-1:0] reqs);
        logic [NM-1:0] pend;
        int w;
        pend = reqs;
        @(posedge clk);
        #1;
        m_cyc = m_cyc | reqs;
        while (pend != '0) begin
            w = pick(pend, model_last);
            model_last = w;
            exp_grant.push_back(w);
            tenure(w, $urandom_range(1, 3));
            pend[w] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int cnt;
        int snap [NM];
        int aborts;
        bit got;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_s_ctl", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'd0);
        chk("rst_m_ack_err", 64'({m_ack_o, m_err_o, abort_o}), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // Masters 0 and 2 together: 1-cycle latency, dead cycle, then 2
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b1;
        m_cyc[2] = 1'b1;
        model_last = 0;
        exp_grant.push_back(0);
        @(negedge clk);
        chk("latency_idle_cyc", 64'(s_cyc_o), 64'd0);
        @(negedge clk);
        chk("latency_cyc", 64'(s_cyc_o), 64'd1);
        chk("first_grant", 64'(grant_o), 64'b0001);
        @(posedge clk);
        #1;
        do_beat(0, 1'b1, 36'h40, 32'hA5A5_0001, 4'hF);
        m_cyc[0] = 1'b0;
        model_last = 2;
        exp_grant.push_back(2);
        @(negedge clk);
        @(negedge clk);
        chk("dead_cycle_idle", 64'(grant_o), 64'd0);
        @(negedge clk);
        chk("second_grant", 64'(grant_o), 64'b0100);
        @(posedge clk);
        #1;
        do_beat(2, 1'b0, 36'h40, 32'h0, 4'hF);
        m_cyc[2] = 1'b0;

        // Master 1 three-beat atomic window while master 3 waits
        @(posedge clk);
        #1;
        m_cyc[1] = 1'b1;
        model_last = 1;
        exp_grant.push_back(1);
        wait_grant(1);
        @(posedge clk);
        #1;
        m_cyc[3] = 1'b1;
        do_beat(1, 1'b1, 36'h000000100, 32'hDEADBEEF, 4'hF);
        do_beat(1, 1'b0, 36'h000000100, 32'h0, 4'hF);
        do_beat(1, 1'b1, 36'h000000100, 32'h12345678, 4'hF);
        m_cyc[1] = 1'b0;
        model_last = 3;
        exp_grant.push_back(3);
        tenure(3, 1);

        // All four request continuously for 16 tenures
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NM; k++) snap[k] = grant_cnt[k];
        m_cyc = '1;
        for (int t = 0; t < 16; t++) begin
            w = pick('1, model_last);
            model_last = w;
            exp_grant.push_back(w);
            tenure(w, 1);
            if (t < 15) begin
                @(posedge clk);
                #1;
                m_cyc[w] = 1'b1;
            end
        end
        m_cyc = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NM; k++) chk("fair_share", 64'(grant_cnt[k] - snap[k]), 64'd4);

        // Watchdog: slave never acks master 3
        stall = 1'b1;
        model_last = 3;
        exp_grant.push_back(3);
        exp_err.push_back(3);
        m_adr[3*AW +: AW] = 36'h200;
        m_we[3]  = 1'b0;
        m_cyc[3] = 1'b1;
        m_stb[3] = 1'b1;
        cnt = 0;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (m_err_o != '0) begin
                got = 1'b1;
                break;
            end
            if (s_stb_o) cnt++;
        end
        if (!got) fail("err_wait", "timeout");
        chk("stall_cycles", 64'(cnt), 64'(TMO));
        @(posedge clk);
        #1;
        m_cyc[3] = 1'b0;
        m_stb[3] = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("abort_one_cycle", 64'({abort_o, m_err_o}), 64'd0);
        chk("abort_grant_clear", 64'(grant_o), 64'd0);
        contest(4'b0001);

        // Ack lands in the cycle the watchdog would expire
        aborts = abort_cnt;
        fixed_delay = TMO - 1;
        @(posedge clk);
        #1;
        m_cyc[2] = 1'b1;
        model_last = 2;
        exp_grant.push_back(2);
        tenure(2, 1);
        fixed_delay = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("ack_beats_expiry", 64'(abort_cnt - aborts), 64'd0);

        // Randomised contention
        for (int r = 0; r < 20; r++) contest(NM'($urandom_range(1, 15)));

        // Async reset mid-read
        stall = 1'b1;
        @(posedge clk);
        #1;
        m_cyc[1] = 1'b1;
        w = pick(4'b0010, model_last);
        model_last = w;
        exp_grant.push_back(w);
        wait_grant(1);
        @(posedge clk);
        #1;
        m_adr[1*AW +: AW] = 36'h100;
        m_we[1]  = 1'b0;
        m_stb[1] = 1'b1;
        @(negedge clk);
        chk("pre_reset_cyc", 64'(s_cyc_o), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_cyc", 64'({s_cyc_o, s_stb_o}), 64'd0);
        chk("async_rst_grant", 64'(grant_o), 64'd0);
        chk("async_rst_ack", 64'({m_ack_o, m_err_o}), 64'd0);
        m_cyc = '0;
        m_stb = '0;
        stall = 1'b0;
        model_last = NM - 1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        contest(4'b0011);

        repeat (5) @(negedge clk);
        chk("ack_queue_empty", 64'(exp_ack.size()), 64'd0);
        chk("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
        chk("err_queue_empty", 64'(exp_err.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
